kuuga_mem_port_arbiter: RTL

//  Shares one AXI4-Lite master port between the instruction-cache miss path and the data-cache miss/write path.

---
 rtl/kuuga_mem_port_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/kuuga_mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one AXI4-Lite master between the I-cache read path and the D-cache read/write path, one transaction at a time.
// Optional ARB_PERF_CNT_EN adds saturating grant and wait-cycle counters.
module kuuga_mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DATA_PRIO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_gnt_o,
  output logic                i_rvalid_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [ADDR_W-1:0]   m_araddr_o,
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_rvalid_i,
  output logic                m_rready_o,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  input  logic                m_bvalid_i,
  output logic                m_bready_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_i_gnt_o,
  output logic [31:0]         perf_d_gnt_o,
  output logic [31:0]         perf_wait_o
`endif
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B} state_t;

  state_t              state_q;
  logic                owner_d_q;
  logic                rr_q;
  logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic                i_rvalid_q, d_rvalid_q;
  logic [ADDR_W-1:0]   araddr_q, awaddr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                idle_ok, pick_d, aw_done_d, w_done_d;

  // Grant is gated by rst so a held request cannot be granted while reset is asserted.
  assign idle_ok   = (state_q == IDLE) && !rst;
  assign pick_d    = d_req_i && (!i_req_i || (DATA_PRIO != 0) || rr_q);
  assign d_gnt_o   = idle_ok && pick_d;
  assign i_gnt_o   = idle_ok && i_req_i && !pick_d;
  assign aw_done_d = !awvalid_q || m_awready_i;
  assign w_done_d  = !wvalid_q || m_wready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_d_q  <= 1'b0;
      rr_q       <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_gnt_o || i_gnt_o) begin
            owner_d_q <= d_gnt_o;
            rr_q      <= i_gnt_o;
            if (d_gnt_o && d_we_i) begin
              awaddr_q  <= d_addr_i;
              wdata_q   <= d_wdata_i;
              wstrb_q   <= d_be_i;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_A;
            end else begin
              araddr_q  <= d_gnt_o ? d_addr_i : i_addr_i;
              arvalid_q <= 1'b1;
              state_q   <= RD_A;
            end
          end
        end
        RD_A: begin
          if (m_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_D;
          end
        end
        RD_D: begin
          if (m_rvalid_i) begin
            rready_q   <= 1'b0;
            rdata_q    <= m_rdata_i;
            d_rvalid_q <= owner_d_q;
            i_rvalid_q <= !owner_d_q;
            state_q    <= IDLE;
          end
        end
        WR_A: begin
          // AW and W complete independently; move on once both have been taken.
          if (m_awready_i) awvalid_q <= 1'b0;
          if (m_wready_i)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (m_bvalid_i) begin
            bready_q   <= 1'b0;
            d_rvalid_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_rvalid_o  = i_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign rdata_o     = rdata_q;
  assign m_araddr_o  = araddr_q;
  assign m_arvalid_o = arvalid_q;
  assign m_rready_o  = rready_q;
  assign m_awaddr_o  = awaddr_q;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = wstrb_q;
  assign m_wvalid_o  = wvalid_q;
  assign m_bready_o  = bready_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_q, perf_d_q, perf_w_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_w_q <= '0;
    end else begin
      if (i_gnt_o && (perf_i_q != '1)) perf_i_q <= perf_i_q + 32'd1;
      if (d_gnt_o && (perf_d_q != '1)) perf_d_q <= perf_d_q + 32'd1;
      if ((i_req_i || d_req_i) && !(i_gnt_o || d_gnt_o) && (perf_w_q != '1))
        perf_w_q <= perf_w_q + 32'd1;
    end
  end

  assign perf_i_gnt_o = perf_i_q;
  assign perf_d_gnt_o = perf_d_q;
  assign perf_wait_o  = perf_w_q;
`endif

endmodule
